// File: rtl/alu_result_serializer.sv
// ALU result serializer: 4-deep FIFO of {overflow, carry, result} words, framed LSB-first onto sdo.
// Optional even-parity bit after the data bits when ALU_RESULT_SER_PARITY_EN is defined.
module alu_result_serializer #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_result,
   input  logic                     in_carry,
   input  logic                     in_overflow,
   output logic                     in_ready,
   output logic                     sdo,
   output logic                     busy,
   output logic                     frame_done,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned WORD_W   = 10;
   localparam int unsigned PTR_W    = $clog2(DEPTH);
   localparam int unsigned FCNT_W   = PTR_W + 1;
   localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned LAST_IDX = WORD_W - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef ALU_RESULT_SER_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   word_q;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [FCNT_W-1:0]   count_d;
   logic                push, pop, empty, bit_end, frame_end;
   logic                sdo_nxt, busy_nxt, done_nxt;

   assign push    = in_valid & in_ready;
   assign empty   = (fifo_count == '0);
   assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // FIFO storage; occupancy and ready are registered from the same next count
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= {in_overflow, in_carry, in_result};
      end
   end

   always_comb begin
      count_d = fifo_count;
      case ({push, pop})
         2'b10:   count_d = fifo_count + FCNT_W'(1);
         2'b01:   count_d = fifo_count - FCNT_W'(1);
         default: count_d = fifo_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         in_ready   <= 1'b1;
         word_q     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            word_q <= mem[rd_ptr];
         end
         fifo_count <= count_d;
         in_ready   <= (count_d != FCNT_W'(DEPTH));
      end
   end

   // FSM state and bit timing counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next state; pop happens on the edge that enters START
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      pop       = 1'b0;
      frame_end = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!empty) begin
               state_d = S_START;
               pop     = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_W'(LAST_IDX)) begin
                  idx_d = '0;
`ifdef ALU_RESULT_SER_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef ALU_RESULT_SER_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               frame_end = 1'b1;
               cnt_d     = '0;
               idx_d     = '0;
               if (!empty) begin
                  state_d = S_START;
                  pop     = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Output values for the upcoming state, registered below
   always_comb begin
      sdo_nxt  = 1'b1;
      busy_nxt = (state_d != S_IDLE);
      done_nxt = frame_end;
      case (state_d)
         S_START: sdo_nxt = 1'b0;
         S_DATA:  sdo_nxt = word_q[idx_d];
`ifdef ALU_RESULT_SER_PARITY_EN
         S_PARITY: sdo_nxt = ^word_q;
`endif
         default: sdo_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sdo        <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sdo        <= sdo_nxt;
         busy       <= busy_nxt;
         frame_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: scoreboard of accepted words checked bit-by-bit against sdo.
module tb_alu_result_serializer;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
`ifdef ALU_RESULT_SER_PARITY_EN
   localparam int unsigned NBITS = 13;
`else
   localparam int unsigned NBITS = 12;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_result;
   logic       in_carry;
   logic       in_overflow;
   logic       in_ready;
   logic       sdo;
   logic       busy;
   logic       frame_done;
   logic [2:0] fifo_count;

   int n_cmp = 0;
   int n_err = 0;
   int frames_seen = 0;
   int done_pulses = 0;
   int gaps = 0;
   logic [9:0] sb [$];

   alu_result_serializer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_result   (in_result),
      .in_carry    (in_carry),
      .in_overflow (in_overflow),
      .in_ready    (in_ready),
      .sdo         (sdo),
      .busy        (busy),
      .frame_done  (frame_done),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected line levels: start, 10 data bits LSB-first, optional parity, stop
   function automatic logic [NBITS-1:0] frame_bits(input logic [9:0] w);
      logic [NBITS-1:0] b;
      b        = '1;
      b[0]     = 1'b0;
      b[10:1]  = w;
`ifdef ALU_RESULT_SER_PARITY_EN
      b[11]    = ^w;
`endif
      b[NBITS-1] = 1'b1;
      return b;
   endfunction

   always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

   // Frame monitor: every cycle of every frame compared against the scoreboard head
   initial begin : monitor
      logic [NBITS-1:0] fb;
      logic [9:0]       w;
      bit               abort;
      forever begin
         @(negedge clk);
         if (rst) sb.delete();
         while (!rst && sdo === 1'b0) begin
            check("frame_expected", 32'(sb.size() > 0), 32'd1);
            w = (sb.size() > 0) ? sb.pop_front() : 10'd0;
            fb = frame_bits(w);
            abort = 1'b0;
            for (int k = 0; k < NBITS * CPB; k++) begin
               if (k > 0) @(negedge clk);
               if (rst) begin
                  abort = 1'b1;
                  sb.delete();
                  break;
               end
               check("sdo", 32'(sdo), 32'(fb[k / CPB]));
               if (k % CPB == 0) check("busy_in_frame", 32'(busy), 32'd1);
            end
            if (abort) break;
            @(negedge clk);
            if (rst) begin
               sb.delete();
               break;
            end
            check("frame_done", 32'(frame_done), 32'd1);
            frames_seen++;
            if (sdo === 1'b1 && sb.size() > 0) gaps++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic drive_word(input logic [9:0] w);
      {in_overflow, in_carry, in_result} = w;
   endtask

   // Present a word (in_valid left high) and wait until it is accepted
   task automatic send(input logic [9:0] w);
      bit ok = 1'b0;
      in_valid = 1'b1;
      drive_word(w);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            sb.push_back(w);
            ok = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
      end
      check("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && busy === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      check("drain", 32'(done), 32'd1);
      @(negedge clk);
   endtask

   initial begin : stim
      int  f0;
      bit  ok;
      bit  any_busy;
      logic [9:0] w;

      rst = 1'b1;
      in_valid = 1'b0;
      drive_word(10'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_sdo", 32'(sdo), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_count", 32'(fifo_count), 32'd0);
         check("idle_ready", 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;

      // Single word 0x5A, carry=1, overflow=0; start bit one edge after acceptance
      send({1'b0, 1'b1, 8'h5A});
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_pre_sdo", 32'(sdo), 32'd1);
      check("lat_pre_count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      check("lat_sdo", 32'(sdo), 32'd0);
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_count", 32'(fifo_count), 32'd0);
      wait_idle();
      check("single_frames", 32'(frames_seen), 32'd1);
      check("single_done", 32'(done_pulses), 32'd1);

      // A few random single words, plus all-ones and all-zeros corners
      for (int i = 0; i < 5; i++) begin
         w = (i == 0) ? 10'h3FF : (i == 1) ? 10'h000 : 10'($urandom);
         @(posedge clk);
         #1;
         send(w);
         in_valid = 1'b0;
         wait_idle();
      end
      check("random_frames", 32'(frames_seen), 32'd6);

      // Burst of six with in_valid held: five accepted, sixth after the first pop while full
      @(posedge clk);
      #1;
      f0 = frames_seen;
      gaps = 0;
      for (int i = 0; i < 5; i++) send(10'($urandom));
      @(negedge clk);
      check("full_count", 32'(fifo_count), 32'(DEPTH));
      check("full_ready", 32'(in_ready), 32'd0);
      w = 10'($urandom);
      drive_word(w);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check("full_wait", 32'(ok), 32'd1);
      check("pop_while_full_count", 32'(fifo_count), 32'(DEPTH - 1));
      if (ok) sb.push_back(w);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("refill_count", 32'(fifo_count), 32'(DEPTH));
      wait_idle();
      check("burst_frames", 32'(frames_seen - f0), 32'd6);
      check("burst_gaps", 32'(gaps), 32'd0);
      check("burst_done", 32'(done_pulses), 32'(frames_seen));

      // Reset during DATA bit 5 with two words queued
      @(posedge clk);
      #1;
      send(10'h155);
      send(10'h2AA);
      send(10'h0F0);
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_count", 32'(fifo_count), 32'd2);
      check("rst_pre_busy", 32'(busy), 32'd1);
      repeat (6 * CPB) @(posedge clk);
      #1;
      f0 = frames_seen;
      rst = 1'b1;
      in_valid = 1'b1;
      drive_word(10'h1C3);
      @(negedge clk);
      @(negedge clk);
      check("rst_sdo", 32'(sdo), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_done", 32'(frame_done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_no_accept", 32'(fifo_count), 32'd0);
      any_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || sdo !== 1'b1) any_busy = 1'b1;
      end
      check("rst_quiet", 32'(any_busy), 32'd0);
      check("rst_no_frames", 32'(frames_seen - f0), 32'd0);
      check("total_done", 32'(done_pulses), 32'(frames_seen));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
